// File: rtl/sync_fifo_param_if.sv
// Handshake/bus bundle for sync_fifo_param.
// master : producer/consumer side, drives requests and write data and
//          observes read data, fill level and status.
// slave  : the FIFO itself.
// Signals: wr/data_in (write), rd (read), flush, clear_err (commands),
//          data_out/data_valid (read return), count and level flags,
//          fifo_overflow/fifo_underflow (sticky errors).
interface sync_fifo_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd;
   logic                  flush;
   logic                  clear_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  fifo_overflow;
   logic                  fifo_underflow;

   modport master (
      output wr, data_in, rd, flush, clear_err,
      input  data_out, data_valid, count, full, empty,
             almost_full, almost_empty, fifo_overflow, fifo_underflow
   );

   modport slave (
      input  wr, data_in, rd, flush, clear_err,
      output data_out, data_valid, count, full, empty,
             almost_full, almost_empty, fifo_overflow, fifo_underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, programmable
// almost-full/almost-empty, registered read data with valid strobe,
// synchronous flush and sticky overflow/underflow flags.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - sync_fifo_param_if.slave (requests, read data, status)
module sync_fifo_param #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_param_if.slave  bus
);

   localparam int                  DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_FULL  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] CNT_AFULL = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] CNT_AEMPT = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  data_valid_q;
   logic                  overflow_q;
   logic                  underflow_q;

   logic full_w;
   logic empty_w;
   logic rd_accept;
   logic wr_accept;
   logic ovf_set;
   logic unf_set;

   // Flags decode only from the registered count, never from inputs.
   assign full_w  = (count_q == CNT_FULL);
   assign empty_w = (count_q == '0);

   // Flush swallows both requests, so nothing is accepted or flagged.
   assign rd_accept = ~bus.flush & bus.rd & ~empty_w;
   assign wr_accept = ~bus.flush & bus.wr & (~full_w | rd_accept);
   assign ovf_set   = ~bus.flush & bus.wr & ~wr_accept;
   assign unf_set   = ~bus.flush & bus.rd & ~rd_accept;

   // Storage is not reset; contents are only meaningful behind rptr..wptr.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else if (bus.flush) begin
         wptr         <= '0;
         rptr         <= '0;
         count_q      <= '0;
         data_valid_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_accept) begin
            rptr       <= rptr + 1'b1;
            data_out_q <= mem[rptr[ADDR_WIDTH-1:0]];
         end
         data_valid_q <= rd_accept;
         case ({wr_accept, rd_accept})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // A new error in the same cycle as clear_err keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end else if (bus.clear_err) begin
            overflow_q <= 1'b0;
         end
         if (unf_set) begin
            underflow_q <= 1'b1;
         end else if (bus.clear_err) begin
            underflow_q <= 1'b0;
         end
      end
   end

   assign bus.data_out       = data_out_q;
   assign bus.data_valid     = data_valid_q;
   assign bus.count          = count_q;
   assign bus.full           = full_w;
   assign bus.empty          = empty_w;
   assign bus.almost_full    = (count_q >= CNT_AFULL);
   assign bus.almost_empty   = (count_q <= CNT_AEMPT);
   assign bus.fifo_overflow  = overflow_q;
   assign bus.fifo_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sync_fifo_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: an ordered queue of stored words plus expected
   // read-return and sticky error state.
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_dout;
   logic          exp_valid;
   logic          exp_ovf;
   logic          exp_unf;
   int            wrote;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, int'(bus.count), n);
      chk({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
      chk({tag, ".empty"}, int'(bus.empty), int'(n == 0));
      chk({tag, ".afull"}, int'(bus.almost_full), int'(n >= AF));
      chk({tag, ".aempty"}, int'(bus.almost_empty), int'(n <= AE));
      chk({tag, ".valid"}, int'(bus.data_valid), int'(exp_valid));
      chk({tag, ".dout"}, int'(bus.data_out), int'(exp_dout));
      chk({tag, ".ovf"}, int'(bus.fifo_overflow), int'(exp_ovf));
      chk({tag, ".unf"}, int'(bus.fifo_underflow), int'(exp_unf));
   endtask

   // One clock cycle: drive inputs, advance model, sample 1 ns after the edge.
   task automatic cyc(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic fl, input logic clr);
      bit can_rd, can_wr;
      bus.wr        = w;
      bus.data_in   = d;
      bus.rd        = r;
      bus.flush     = fl;
      bus.clear_err = clr;
      if (fl) begin
         q.delete();
         exp_valid = 1'b0;
         if (clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
         end
      end else begin
         can_rd = r && (q.size() > 0);
         can_wr = w && ((q.size() < DEPTH) || can_rd);
         if (w && !can_wr) exp_ovf = 1'b1;
         else if (clr)     exp_ovf = 1'b0;
         if (r && !can_rd) exp_unf = 1'b1;
         else if (clr)     exp_unf = 1'b0;
         exp_valid = can_rd;
         if (can_rd) exp_dout = q.pop_front();
         if (can_wr) begin
            q.push_back(d);
            wrote++;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      bit w, r;
      bus.wr = 1'b0; bus.data_in = '0; bus.rd = 1'b0;
      bus.flush = 1'b0; bus.clear_err = 1'b0;
      model_reset();
      wrote = 0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Fill 0x00..0x0F
      for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);

      // Write to full FIFO -> overflow, then clear
      cyc("ovf", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      cyc("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Simultaneous rd+wr on full FIFO, then drain
      cyc("full_rw", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc("drain_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Empty with rd+wr -> underflow, write lands
      cyc("unf", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      cyc("unf_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc("unf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Random stream of 40 words across pointer wrap
      wrote = 0;
      for (int c = 0; c < 600 && (wrote < 40 || q.size() > 0); c++) begin
         w = (wrote < 40) && ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
         r = ($urandom_range(0, 2) != 0) && (q.size() > 0);
         cyc("stream", w, DW'($urandom), r, 1'b0, 1'b0);
      end
      chk("stream_done", int'(wrote >= 40 && q.size() == 0), 1);

      // Flush at count 7 with an underflow flag standing
      cyc("pre_unf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cyc("fill7", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      cyc("pre_flush_rd", 1'b1, 8'hC7, 1'b1, 1'b0, 1'b0);
      chk("count7", int'(bus.count), 7);
      cyc("flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      cyc("post_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges
      cyc("pre_rst_w", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cyc("pre_rst_rw", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      bus.wr = 1'b0; bus.rd = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("post_rst_w", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      cyc("post_rst_w2", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
      cyc("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc("post_rst_rd2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
